lut_layer_pipe: RTL

Parametrised, runtime-programmable LogicNets layer: NEURONS truth-table neurons, each mapping FANIN quantised inputs of IN_BITS to an OUT_BITS activation. It supersedes the per-neuron fixed-ROM modules, which are combinational and hard-coded. Tables are loaded through a configuration port and lookups run through a two-stage valid/ready pipeline. It sits between adjacent layers of the classification datapath and can be retrained without regenerating RTL.

---
 rtl/lut_layer_pkg.sv | 25 ++
 rtl/lut_neuron_table.sv | 25 ++
 rtl/lut_layer_pipe.sv | 105 ++++++++++
 3 files changed

// File: rtl/lut_layer_pkg.sv
// Shared types and slicing helpers for the runtime-programmable LUT layer.
package lut_layer_pkg;

  typedef enum logic [1:0] {
    CFG   = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } lut_state_e;

  // One table address is the concatenation of all fan-in slots of a neuron.
  function automatic int addr_w(input int fanin, input int in_bits);
    return fanin * in_bits;
  endfunction

  // LSB of neuron n's field in a flat per-neuron bus of the given field width.
  function automatic int field_lsb(input int n, input int width);
    return n * width;
  endfunction

  // LSB of fan-in slot k inside one neuron's address field (slot 0 in LSBs).
  function automatic int slot_lsb(input int k, input int in_bits);
    return k * in_bits;
  endfunction

endpackage

// File: rtl/lut_neuron_table.sv
// One neuron's truth table: synchronous write, asynchronous read, no reset,
// so it maps onto distributed RAM and keeps its contents across rst_n.
module lut_neuron_table #(
  parameter int ADDR_W   = 6,
  parameter int OUT_BITS = 2
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [OUT_BITS-1:0] wdata,
  input  logic [ADDR_W-1:0]   raddr,
  output logic [OUT_BITS-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [OUT_BITS-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lut_layer_pipe.sv
// LogicNets layer of NEURONS programmable truth tables behind a two-stage
// valid/ready pipeline, with a CFG/RUN/DRAIN mode FSM guarding table loads.
module lut_layer_pipe
  import lut_layer_pkg::*;
#(
  parameter int NEURONS  = 8,
  parameter int FANIN    = 3,
  parameter int IN_BITS  = 2,
  parameter int OUT_BITS = 2,
  localparam int ADDR_W  = addr_w(FANIN, IN_BITS),
  localparam int NW      = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cfg_start,
  input  logic                         cfg_done,
  input  logic                         cfg_we,
  input  logic [NW-1:0]                cfg_neuron,
  input  logic [ADDR_W-1:0]            cfg_addr,
  input  logic [OUT_BITS-1:0]          cfg_data,
  output logic                         cfg_busy,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NEURONS*ADDR_W-1:0]    in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NEURONS*OUT_BITS-1:0]  out_data,
  output lut_state_e                   state
);

  // Handshake: a beat moves across any valid/ready pair on a rising edge where
  // both are high; a stage advances when it is empty or its consumer takes it.
  lut_state_e                   state_next;
  logic                         v1, v2;
  logic                         adv1, adv2, accept, pipe_empty;
  logic [NEURONS*ADDR_W-1:0]    s1_data;
  logic [NEURONS*OUT_BITS-1:0]  lookup;

  assign adv2      = !v2 || out_ready;
  assign adv1      = adv2;
  assign in_ready  = (state == RUN) && (!v1 || adv1);
  assign accept    = in_valid && in_ready;
  assign out_valid = v2;
  // A beat accepted alongside cfg_start still needs draining.
  assign pipe_empty = !v1 && !v2 && !accept;

  always_comb begin
    state_next = state;
    case (state)
      CFG:     if (cfg_done) state_next = RUN;
      RUN:     if (cfg_start) state_next = pipe_empty ? CFG : DRAIN;
      DRAIN:   if (!v1 && !v2) state_next = CFG;
      default: state_next = CFG;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= CFG;
      cfg_busy <= 1'b1;
    end else begin
      state    <= state_next;
      cfg_busy <= (state_next != RUN);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      s1_data  <= '0;
      out_data <= '0;
    end else begin
      if (accept) begin
        v1      <= 1'b1;
        s1_data <= in_data;
      end else if (adv1) begin
        v1 <= 1'b0;
      end
      if (adv2) begin
        v2 <= v1;
        if (v1) out_data <= lookup;
      end
    end
  end

  // Out-of-range neuron indices match no table and are dropped.
  for (genvar n = 0; n < NEURONS; n++) begin : g_neuron
    logic we;
    assign we = cfg_we && (state == CFG) && (cfg_neuron == NW'(n));

    lut_neuron_table #(
      .ADDR_W   (ADDR_W),
      .OUT_BITS (OUT_BITS)
    ) u_table (
      .clk   (clk),
      .we    (we),
      .waddr (cfg_addr),
      .wdata (cfg_data),
      .raddr (s1_data[field_lsb(n, ADDR_W) +: ADDR_W]),
      .rdata (lookup[field_lsb(n, OUT_BITS) +: OUT_BITS])
    );
  end

endmodule
